// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit.
// Shift-add multiply and restoring divide share one accumulator.
module muldiv_unit #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3,
  parameter int ITER   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [REG_AW-1:0] dest,
  output logic              busy,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_ws,
  output logic [WIDTH-1:0]  wb_wd
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [REG_AW-1:0]   dest_q, dest_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [REG_AW-1:0]   ws_q, ws_d;
  logic [WIDTH-1:0]    wd_q, wd_d;

  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      trial;
  logic [2*WIDTH-1:0]  step;
  logic [WIDTH-1:0]    res;

  // Multiply: upper half accumulates, multiplier drains out of the low half.
  // Divide: upper half is the remainder, low half shifts dividend into quotient.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, a_q} : '0);
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}
            - {1'b0, b_q};
    if (op_q[1]) begin
      if (trial[WIDTH])
        step = {acc_q[2*WIDTH-2:0], 1'b0};
      else
        step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    unique case (op_q)
      2'b00:   res = step[WIDTH-1:0];
      2'b01:   res = step[2*WIDTH-1:WIDTH];
      2'b10:   res = step[WIDTH-1:0];
      default: res = step[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ws_d    = ws_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dest_d  = dest;
          cnt_d   = '0;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, a}
                          : {{WIDTH{1'b0}}, b};
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            ws_d    = dest_q;
            wd_d    = res;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ws_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ws_q    <= ws_d;
      wd_q    <= wd_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign wb_we = (state_q == S_DONE) && !kill;
  assign wb_ws = ws_q;
  assign wb_wd = wd_q;

endmodule
